// File: rtl/fir_cfg_regfile.sv
// Configuration register bank and tap-RAM arbiter for the FIR block.
// Writes are accepted combinationally; reads go through a small response FSM.
module fir_cfg_regfile #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_data,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   ap_start,
  input  logic                   engine_done,
  output logic [pDATA_WIDTH-1:0] data_length
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAP_WAIT,
    S_RESP
  } rd_state_t;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32'h20 + 4 * pTAP_NUM);

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
  endfunction

  rd_state_t state, state_d;
  logic      ap_done, ap_idle;
  logic      wr_fire, rd_fire, wr_tap_fire, rd_tap_fire, start_fire, ctrl_rd;
  logic      done_view, idle_view;
  logic [pDATA_WIDTH-1:0] reg_rdata;

  // Write always wins; a read is only taken in IDLE when no write is pending,
  // which also guarantees a single tap RAM access per cycle.
  assign wr_fire     = wr_valid & ~axis_rst;
  assign rd_fire     = rd_valid & ~wr_valid & (state == S_IDLE) & ~axis_rst;
  assign wr_tap_fire = wr_fire & is_tap(wr_addr) & ap_idle;
  assign rd_tap_fire = rd_fire & is_tap(rd_addr) & ap_idle;
  assign start_fire  = wr_fire & (wr_addr == ADDR_CTRL) & wr_data[0] & ap_idle;
  assign ctrl_rd     = rd_fire & (rd_addr == ADDR_CTRL);

  // A completion landing on the same cycle as a status read is reported by it.
  assign done_view = ap_done | engine_done;
  assign idle_view = ap_idle | engine_done;

  assign rsp_valid = (state == S_RESP);

  always_comb begin
    reg_rdata = '0;
    if (rd_addr == ADDR_CTRL) begin
      reg_rdata = pDATA_WIDTH'({idle_view, done_view, 1'b0});
    end else if (rd_addr == ADDR_LEN) begin
      reg_rdata = data_length;
    end
  end

  always_comb begin
    wr_ready = wr_fire;
    rd_ready = rd_fire;
    tap_EN   = 1'b0;
    tap_WE   = '0;
    tap_A    = '0;
    tap_Di   = '0;
    if (wr_tap_fire) begin
      tap_EN = 1'b1;
      tap_WE = '1;
      tap_A  = wr_addr - TAP_BASE;
      tap_Di = wr_data;
    end else if (rd_tap_fire) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr - TAP_BASE;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (rd_fire) state_d = rd_tap_fire ? S_TAP_WAIT : S_RESP;
      S_TAP_WAIT: state_d = S_RESP;
      S_RESP:     if (rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state       <= S_IDLE;
      rsp_data    <= '0;
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      data_length <= '0;
    end else begin
      state    <= state_d;
      ap_start <= start_fire;
      if (wr_fire && (wr_addr == ADDR_LEN) && ap_idle) begin
        data_length <= wr_data;
      end
      if (rd_fire && !rd_tap_fire) begin
        rsp_data <= reg_rdata;
      end else if (state == S_TAP_WAIT) begin
        rsp_data <= tap_Do;
      end
      if (start_fire) begin
        ap_done <= 1'b0;
        ap_idle <= 1'b0;
      end else if (engine_done) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else if (ctrl_rd) begin
        ap_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_cfg_regfile.md
Name: fir_cfg_regfile

Overview:
- Configuration register bank and tap-coefficient RAM arbiter for the FIR block.
- Sits between the AXI4-Lite write and read front-ends and the FIR engine.
- Consumes the latched read address from the read front-end and returns read data plus a valid flag.
- Services writes from the write front-end, owns the single-port tap RAM, and generates the ap_start/ap_done/ap_idle control bits.

Parameters:
- pADDR_WIDTH, 12, byte-address width of config space
- pDATA_WIDTH, 32, register and tap data width
- pTAP_NUM, 11, number of tap coefficients stored in tap RAM

Ports:
- axis_clk  in  1  single clock, all logic on rising edge
- axis_rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request from write front-end
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  pADDR_WIDTH  write byte address
- wr_data  in  pDATA_WIDTH  write data
- rd_valid  in  1  read request from read front-end
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  pADDR_WIDTH  read byte address (config_read_address)
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  read front-end has taken rsp_data
- rsp_data  out  pDATA_WIDTH  read data
- tap_EN  out  1  tap RAM enable
- tap_WE  out  4  tap RAM byte write enables
- tap_A  out  pADDR_WIDTH  tap RAM byte address
- tap_Di  out  pDATA_WIDTH  tap RAM write data
- tap_Do  in  pDATA_WIDTH  tap RAM read data, valid one cycle after tap_EN with tap_WE=0
- ap_start  out  1  one-cycle start pulse to engine
- engine_done  in  1  one-cycle completion pulse from engine
- data_length  out  pDATA_WIDTH  number of samples to process

Behaviour:
- Reset values:
  - Outputs: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0, ap_start=0, data_length=0.
  - Internal: ap_done=0, ap_idle=1.
  - Reset mid-transaction aborts it; no response is issued.
- Address map:
  - 0x00 ap_ctrl: bit0 ap_start (W1), bit1 ap_done (RO, sticky), bit2 ap_idle (RO); other bits read as 0.
  - 0x10 data_length (RW).
  - 0x20 + 4*k, for k = 0..pTAP_NUM-1, tap[k] (RW, stored in RAM at tap_A = 4*k).
  - Any other address: write is ignored, read returns 0.
- Write path:
  - wr_ready pulses high for one cycle in the cycle a write is accepted.
  - Register writes take effect the cycle after acceptance.
  - Tap writes drive tap_EN=1, tap_WE=4'hF, tap_A and tap_Di in that same accepting cycle.
  - While ap_idle=0, data_length and tap writes are accepted but discarded (no RAM access).
- ap_start and control bits:
  - Writing 1 to bit0 while ap_idle=1 raises ap_start for exactly one cycle, clears ap_idle and clears ap_done in the same cycle.
  - Writing bit0 while ap_idle=0 is ignored.
  - engine_done sets ap_done=1 and ap_idle=1 on the next edge.
  - ap_done clears when a read of 0x00 is accepted.
  - If engine_done coincides with that read, the read returns ap_done=1 and ap_done stays 1.
- Read FSM, states IDLE, TAP_WAIT, RESP:
  - IDLE, rd_valid, register address: rd_ready=1, capture value, go to RESP (rsp_valid on the next cycle, 1-cycle latency).
  - IDLE, rd_valid, tap address: rd_ready=1, tap_EN=1, tap_WE=0, go to TAP_WAIT.
  - TAP_WAIT: capture tap_Do into rsp_data, go to RESP (2-cycle latency).
  - RESP: hold rsp_valid=1 and rsp_data stable until rsp_ready=1, then return to IDLE; rsp_valid drops on the next cycle.
  - rd_valid is not accepted outside IDLE.
  - Tap read while ap_idle=0 returns 0 with no RAM access, at 1-cycle latency.
- Arbitration:
  - When wr_valid and rd_valid are both high in IDLE, the write wins and the read is held for the next cycle.
  - At most one tap RAM access occurs per cycle.
  - A write to the address being read in the same cycle is seen by that read.

Test Plan:
- Reset: assert axis_rst 2 cycles -> read 0x00 returns 0x4, data_length=0, rsp_valid=0.
- Write 0x10=64, read 0x10 -> rsp_data=64 one cycle after rd_ready; rsp_valid held until rsp_ready.
- Write taps 0..10 with values k+1, read back 0x20..0x48 -> values 1..11, each with 2-cycle latency and tap_WE=0 on reads.
- Write 0x00=1 -> ap_start high exactly 1 cycle, 0x00 reads 0x0; write tap 0x20=0xDEAD while busy -> no tap_EN; pulse engine_done -> 0x00 reads 0x6 then 0x4.
- Same-cycle wr_valid (0x24=7) and rd_valid (0x24) -> write accepted first, read accepted next cycle, rsp_data=7.
- Read 0x00 coincident with engine_done -> rsp_data bit1=1; next read of 0x00 also shows bit1=1; assert reset during TAP_WAIT -> no response, FSM in IDLE.
